rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and selectable arbitration. It replaces the single-bit, combinational 2:1 select used in datapath glue when several producers share one consumer. Arbitration is round-robin or fixed-priority, with one output register stage. It sits between multiple upstream sources and a single downstream sink.

## Interface
- N, default 4: number of input channels; legal range 2..16.
- W, default 8: data width in bits; must be at least 1.
- RR, default 1: arbitration mode; 1 selects round-robin, 0 selects fixed priority (lowest index wins).
- SW, derived, not overridable: $clog2(N).

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  held word.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  sink accepts the word this cycle.

## Operation
- The output register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid || out_ready, meaning the register is empty or is being drained this cycle.
- Grant, combinational over in_valid:
  - RR=1: search starts at pointer ptr and proceeds ptr, ptr+1, … with wrap-around mod N; the first valid channel wins.
  - RR=0: the lowest valid index wins; ptr is ignored and held at 0.
- in_ready[i] = load_en && grant[i] && !rst. in_ready is never high for a channel whose in_valid is low.
- A transfer happens when in_valid[g] && in_ready[g]. On a transfer the block:
  - sets out_data to in_data[g];
  - sets out_sel to g;
  - sets out_valid to 1;
  - when RR=1, sets ptr to (g+1) mod N; the wrap is correct for N that is not a power of two.
- Drain without reload (out_ready=1 and no input valid): next state EMPTY; out_data and out_sel keep their last values.
- Simultaneous drain and load: the register is overwritten with no bubble, so throughput is 1 word/cycle.
- FULL with out_ready=0:
  - out_data and out_sel stay stable;
  - in_ready is all zero;
  - ptr does not advance.
- ptr advances only on a transfer, never on idle cycles.

## Timing
- Latency: a word accepted at edge k is visible on out_* immediately after edge k, one cycle after in_valid is presented.
- Reset, applied at a sampled rising edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready stays all zero for the whole cycle in which rst is high.
- Reset mid-operation: a held word is discarded with no drain, and in-flight inputs are not accepted.
- Handshake rules:
  - in_ready depends combinationally on in_valid, out_valid, out_ready and ptr.
  - out_valid and out_data depend only on registers; there is no input-to-output combinational path on the sink side.
- Upstream contract: a source keeps in_valid and in_data stable until its transfer completes. The block does not rely on this for correctness, but the bench checks it.

## Structure
- Package rr_mux_pkg holds:
  - mode constants ARB_FIXED=0 and ARB_RR=1;
  - function next_ptr(g, n), which returns (g+1) mod n.
- Sub-module rr_arbiter (parameters N, RR):
  - contains the combinational grant and the ptr register;
  - inputs: clk, rst, req[N], advance;
  - outputs: grant[N] (one-hot) and grant_idx[SW].
- The top level contains load_en, the data/sel/valid register and the in_data slice select.

## Test plan
- Reset: N=4, W=8, all in_valid=1, rst high for 2 cycles -> in_ready=0000 throughout; after reset out_valid=0, out_data=0x00, out_sel=0.
- Single source: channel 2 valid with 0xA5, out_ready=1 -> in_ready=0100 in that cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2.
- Round-robin fairness: RR=1, all four channels continuously valid with data 0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 and data 0x10,0x11,0x12,0x13,0x10, one word per cycle.
- Backpressure: register FULL with 0x11, out_ready=0 for 3 cycles -> out_data=0x11 held and in_ready=0000. When out_ready rises, the next channel loads in that same cycle, with no EMPTY cycle.
- Fixed priority: RR=0, channels 1 and 3 valid -> channel 1 is granted every cycle; channel 3 is granted only after in_valid[1] drops.
- Wrap and reset: N=3; a grant on channel 2 sets ptr to 0, so the next grant with all valid goes to channel 0. Asserting rst while FULL gives out_valid=0 the following cycle and the held word is never seen accepted by the sink.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and helpers for the rr_mux_n block
//
// Purpose: arbitration mode constants and the round-robin pointer helper
// used by rr_arbiter and rr_mux_n.
package rr_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // (g + 1) mod n, written as a compare so that n need not be a power of two.
    function automatic logic [4:0] next_ptr(input logic [4:0] g, input logic [4:0] n);
        return (g == n - 5'd1) ? 5'd0 : g + 5'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin / fixed-priority grant with pointer register
//
// Purpose: picks one requesting channel per cycle. With RR=1 the search starts
// at ptr and wraps; with RR=0 the search always starts at 0 (lowest index wins).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req[N]      per-channel request
//   advance     a transfer on the granted channel happens this cycle
//   grant[N]    one-hot grant, zero when no request
//   grant_idx   binary index of the granted channel
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int RR = ARB_RR,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] ptr;

    // Search order base, base+1, ... mod N; first requester wins. Fixed
    // priority is the same search with base pinned at 0.
    always_comb begin : grant_search
        int  base;
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        base      = (RR != ARB_FIXED) ? int'(ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SW'(idx);
            end
        end
    end

    // Pointer moves past the winner only when a word is actually taken,
    // so stalls and idle cycles leave the rotation where it was.
    always_ff @(posedge clk) begin
        if (rst || RR == ARB_FIXED) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= SW'(next_ptr(5'(grant_idx), 5'(N)));
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel registered mux with valid/ready and selectable arbitration
//
// Purpose: several producers share one consumer through a single output
// register; one word per cycle when the sink keeps out_ready high.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid[N]   per-channel valid
//   in_data[N*W]  channel i at [i*W +: W]
//   in_ready[N]   per-channel accept, one-hot or zero
//   out_valid     output register holds a word
//   out_data[W]   held word
//   out_sel[SW]   channel that supplied out_data
//   out_ready     sink takes the held word this cycle
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    parameter  int RR = ARB_RR,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic          load_en;
    logic          xfer;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  sel_data;

    // Register is free when empty or being drained in this same cycle.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = grant & {N{load_en && !rst}};
    // grant is only ever set on a valid channel, so any ready bit is a transfer.
    assign xfer     = |in_ready;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    // Drain without reload clears valid only; data and sel keep last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - directed self-checking bench for rr_mux_n
module tb_rr_mux_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Round-robin, N=4
    logic [3:0]  rr_valid = '0;
    logic [31:0] rr_data  = '0;
    logic [3:0]  rr_ready;
    logic        rr_ovalid;
    logic [7:0]  rr_odata;
    logic [1:0]  rr_osel;
    logic        rr_oready = 1'b0;

    // Fixed priority, N=4
    logic [3:0]  fp_valid = '0;
    logic [31:0] fp_data  = '0;
    logic [3:0]  fp_ready;
    logic        fp_ovalid;
    logic [7:0]  fp_odata;
    logic [1:0]  fp_osel;
    logic        fp_oready = 1'b0;

    // Round-robin, N=3
    logic [2:0]  n3_valid = '0;
    logic [23:0] n3_data  = '0;
    logic [2:0]  n3_ready;
    logic        n3_ovalid;
    logic [7:0]  n3_odata;
    logic [1:0]  n3_osel;
    logic        n3_oready = 1'b0;

    rr_mux_n #(.N(4), .W(8), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(rr_valid), .in_data(rr_data),
        .in_ready(rr_ready), .out_valid(rr_ovalid), .out_data(rr_odata),
        .out_sel(rr_osel), .out_ready(rr_oready)
    );

    rr_mux_n #(.N(4), .W(8), .RR(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(fp_valid), .in_data(fp_data),
        .in_ready(fp_ready), .out_valid(fp_ovalid), .out_data(fp_odata),
        .out_sel(fp_osel), .out_ready(fp_oready)
    );

    rr_mux_n #(.N(3), .W(8), .RR(1)) u_n3 (
        .clk(clk), .rst(rst), .in_valid(n3_valid), .in_data(n3_data),
        .in_ready(n3_ready), .out_valid(n3_ovalid), .out_data(n3_odata),
        .out_sel(n3_osel), .out_ready(n3_oready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        rr_valid = '0; fp_valid = '0; n3_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rr_valid = 4'b1111;
        rr_data = 32'h13121110;
        rr_oready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (rr_ready !== 4'b0000) begin
                fails++;
                $display("FAIL reset_in_ready cycle %0d: got %b want 0000", c, rr_ready);
            end
            tick();
        end
        tests++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 8'h00 || rr_osel !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=00 s=0",
                     rr_ovalid, rr_odata, rr_osel);
        end
        rst = 1'b0;
        rr_valid = '0;
    endtask

    task automatic test_single;
        do_reset();
        rr_valid = 4'b0100;
        rr_data = 32'h00A50000;
        rr_oready = 1'b1;
        #1;
        tests++;
        if (rr_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_in_ready: got %b want 0100", rr_ready);
        end
        tick();
        rr_valid = '0;
        tests++;
        if (rr_ovalid !== 1'b1 || rr_odata !== 8'hA5 || rr_osel !== 2'd2) begin
            fails++;
            $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=a5 s=2",
                     rr_ovalid, rr_odata, rr_osel);
        end
        tick();
        tests++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 8'hA5 || rr_osel !== 2'd2) begin
            fails++;
            $display("FAIL single_drain: got v=%b d=%h s=%0d want v=0 d=a5 s=2",
                     rr_ovalid, rr_odata, rr_osel);
        end
    endtask

    task automatic test_rr_fairness;
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        do_reset();
        rr_valid = 4'b1111;
        rr_data = 32'h13121110;
        rr_oready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_ready = 4'b0001 << (k % 4);
            exp_data = 8'h10 + 8'(k % 4);
            #1;
            tests++;
            if (rr_ready !== exp_ready) begin
                fails++;
                $display("FAIL rr_in_ready word %0d: got %b want %b", k, rr_ready, exp_ready);
            end
            tick();
            tests++;
            if (rr_ovalid !== 1'b1 || rr_osel !== 2'(k % 4) || rr_odata !== exp_data) begin
                fails++;
                $display("FAIL rr_out word %0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         k, rr_ovalid, rr_osel, rr_odata, k % 4, exp_data);
            end
        end
        rr_valid = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        rr_valid = 4'b0010;
        rr_data = 32'h13121110;
        rr_oready = 1'b1;
        tick();
        rr_oready = 1'b0;
        rr_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (rr_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_in_ready stall %0d: got %b want 0000", c, rr_ready);
            end
            tick();
            tests++;
            if (rr_ovalid !== 1'b1 || rr_odata !== 8'h11 || rr_osel !== 2'd1) begin
                fails++;
                $display("FAIL bp_hold stall %0d: got v=%b d=%h s=%0d want v=1 d=11 s=1",
                         c, rr_ovalid, rr_odata, rr_osel);
            end
        end
        rr_oready = 1'b1;
        #1;
        tests++;
        if (rr_ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 0100", rr_ready);
        end
        tick();
        tests++;
        if (rr_ovalid !== 1'b1 || rr_odata !== 8'h12 || rr_osel !== 2'd2) begin
            fails++;
            $display("FAIL bp_release_out: got v=%b d=%h s=%0d want v=1 d=12 s=2",
                     rr_ovalid, rr_odata, rr_osel);
        end
        rr_valid = '0;
    endtask

    task automatic test_fixed_priority;
        do_reset();
        fp_valid = 4'b1010;
        fp_data = 32'h23002100;
        fp_oready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (fp_ready !== 4'b0010) begin
                fails++;
                $display("FAIL fp_ready ch1 cycle %0d: got %b want 0010", c, fp_ready);
            end
            tick();
            tests++;
            if (fp_osel !== 2'd1 || fp_odata !== 8'h21) begin
                fails++;
                $display("FAIL fp_out ch1 cycle %0d: got s=%0d d=%h want s=1 d=21",
                         c, fp_osel, fp_odata);
            end
        end
        fp_valid = 4'b1000;
        #1;
        tests++;
        if (fp_ready !== 4'b1000) begin
            fails++;
            $display("FAIL fp_ready ch3: got %b want 1000", fp_ready);
        end
        tick();
        tests++;
        if (fp_ovalid !== 1'b1 || fp_osel !== 2'd3 || fp_odata !== 8'h23) begin
            fails++;
            $display("FAIL fp_out ch3: got v=%b s=%0d d=%h want v=1 s=3 d=23",
                     fp_ovalid, fp_osel, fp_odata);
        end
        fp_valid = '0;
    endtask

    task automatic test_wrap_and_reset;
        logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [2:0] exp_ready;
        do_reset();
        n3_valid = 3'b100;
        n3_data = 24'h323130;
        n3_oready = 1'b1;
        #1;
        tests++;
        if (n3_ready !== 3'b100) begin
            fails++;
            $display("FAIL n3_first_ready: got %b want 100", n3_ready);
        end
        tick();
        tests++;
        if (n3_osel !== 2'd2 || n3_odata !== 8'h32) begin
            fails++;
            $display("FAIL n3_first_out: got s=%0d d=%h want s=2 d=32", n3_osel, n3_odata);
        end
        n3_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_ready = 3'b001 << seq[k];
            #1;
            tests++;
            if (n3_ready !== exp_ready) begin
                fails++;
                $display("FAIL n3_wrap_ready word %0d: got %b want %b", k, n3_ready, exp_ready);
            end
            tick();
            tests++;
            if (n3_osel !== seq[k] || n3_odata !== 8'h30 + 8'(seq[k])) begin
                fails++;
                $display("FAIL n3_wrap_out word %0d: got s=%0d d=%h want s=%0d d=%h",
                         k, n3_osel, n3_odata, seq[k], 8'h30 + 8'(seq[k]));
            end
        end
        // Register is FULL; stall the sink and reset over the held word.
        n3_oready = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (n3_ready !== 3'b000) begin
            fails++;
            $display("FAIL n3_rst_ready: got %b want 000", n3_ready);
        end
        tick();
        rst = 1'b0;
        tests++;
        if (n3_ovalid !== 1'b0) begin
            fails++;
            $display("FAIL n3_rst_discard: got out_valid=%b want 0", n3_ovalid);
        end
        n3_oready = 1'b1;
        #1;
        tests++;
        if (n3_ready !== 3'b001) begin
            fails++;
            $display("FAIL n3_post_rst_ready: got %b want 001", n3_ready);
        end
        tick();
        tests++;
        if (n3_ovalid !== 1'b1 || n3_osel !== 2'd0 || n3_odata !== 8'h30) begin
            fails++;
            $display("FAIL n3_post_rst_out: got v=%b s=%0d d=%h want v=1 s=0 d=30",
                     n3_ovalid, n3_osel, n3_odata);
        end
        n3_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_rr_fairness();
        test_backpressure();
        test_fixed_priority();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
